// File: rtl/core_state_dump.sv
// Architectural state readout engine: halts the core, then streams x0..x(RF_DEPTH-1)
// followed by dmem[0..DMEM_WORDS-1] through a single-register valid/ready word port.
module core_state_dump #(
    parameter int RF_DEPTH   = 32,
    parameter int DMEM_WORDS = 512,
    parameter int XLEN       = 32,
    localparam int RF_AW     = $clog2(RF_DEPTH),
    localparam int IDX_W     = $clog2(DMEM_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             halt_req,
    output logic [RF_AW-1:0] rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic             dm_ren,
    output logic [IDX_W-1:0] dm_raddr,
    input  logic [XLEN-1:0]  dm_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic             out_sel,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);

    // state    | meaning
    // IDLE     | waiting for start, core runs freely
    // SETTLE   | halt raised, one cycle for in-flight writeback to land in the RF
    // RF       | stream register-file entry idx
    // DM_REQ   | issue synchronous dmem read of word idx
    // DM_WAIT  | dmem data returns, captured into hold
    // DM_PUSH  | load hold into the output register when the slot frees
    // DRAIN    | final word loaded, waiting for its handshake
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_RF,
        S_DM_REQ,
        S_DM_WAIT,
        S_DM_PUSH,
        S_DRAIN
    } state_t;

    localparam logic [IDX_W-1:0] RF_LAST = IDX_W'(RF_DEPTH - 1);
    localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(DMEM_WORDS - 1);

    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [XLEN-1:0]   hold;
    logic              slot_free;
    logic              load;
    logic [XLEN-1:0]   load_data;
    logic              load_sel;
    logic              load_last;
    logic              hold_en;
    logic              done_nx;

    assign slot_free = !out_valid || out_ready;
    assign busy      = (state != S_IDLE);
    assign halt_req  = (state != S_IDLE);
    assign rf_raddr  = idx[RF_AW-1:0];
    assign dm_raddr  = idx;
    assign dm_ren    = (state == S_DM_REQ);

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        load      = 1'b0;
        load_data = hold;
        load_sel  = 1'b0;
        load_last = 1'b0;
        hold_en   = 1'b0;
        done_nx   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SETTLE;
                    idx_nx   = '0;
                end
            end
            S_SETTLE: begin
                state_nx = S_RF;
                idx_nx   = '0;
            end
            S_RF: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = rf_rdata;
                    if (idx == RF_LAST) begin
                        state_nx = S_DM_REQ;
                        idx_nx   = '0;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end
            end
            S_DM_REQ: begin
                state_nx = S_DM_WAIT;
            end
            S_DM_WAIT: begin
                hold_en  = 1'b1;
                state_nx = S_DM_PUSH;
            end
            S_DM_PUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_sel  = 1'b1;
                    load_last = (idx == DM_LAST);
                    if (idx == DM_LAST) begin
                        state_nx = S_DRAIN;
                    end else begin
                        idx_nx   = idx + IDX_W'(1);
                        state_nx = S_DM_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            done  <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            done  <= done_nx;
            if (hold_en) begin
                hold <= dm_rdata;
            end
        end
    end

    // Fields are only rewritten on a load, so they hold still under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_sel   <= load_sel;
            out_index <= idx;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_core_state_dump.sv
// Self-checking bench for core_state_dump: randomized backpressure and memory contents,
// checked against a word-order reference built directly from the dump rules.
module tb_core_state_dump;
    localparam int RF_DEPTH   = 32;
    localparam int DMEM_WORDS = 512;
    localparam int NWORDS     = RF_DEPTH + DMEM_WORDS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, halt_req, dm_ren, out_valid, out_sel, out_last;
    logic [4:0]  rf_raddr;
    logic [8:0]  dm_raddr, out_index;
    logic [31:0] rf_rdata, dm_rdata, out_data;

    logic [31:0] rf_mem [RF_DEPTH];
    logic [31:0] dm_mem [DMEM_WORDS];
    logic        dm_valid = 1'b0;
    logic [31:0] dm_q = '0;
    logic [31:0] garbage = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    core_state_dump dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .halt_req(halt_req),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dm_ren(dm_ren), .dm_raddr(dm_raddr),
        .dm_rdata(dm_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_index(out_index), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Memory models: async RF port; sync dmem port whose data is junk except the cycle after dm_ren.
    assign rf_rdata = rf_mem[rf_raddr];
    assign dm_rdata = dm_valid ? dm_q : garbage;
    always @(posedge clk) begin
        dm_valid <= dm_ren;
        if (dm_ren) dm_q <= dm_mem[dm_raddr];
        garbage <= $urandom;
        cyc <= cyc + 1;
    end

    logic [31:0] g_data[$];
    logic        g_sel[$];
    logic [8:0]  g_idx[$];
    logic        g_last[$];
    int t_start, first_valid_edge, last_acc_edge, done_edge, done_pulses, stall_changes;
    int halt_gaps, busy_at_done, tail_busy, halt_after_done, dm_ren_count, dm_ren_stall, timed_out;

    task automatic collect(input bit do_start, input int t_given, input int mode,
                           input int second_rel, input int stop_rel, input bit start_on_done,
                           input int tail);
        int n;
        bit r;
        bit first_it = 1'b1;
        bit prev_stall = 1'b0;
        logic [31:0] pd;
        logic ps, pl;
        logic [8:0] pi;
        int stall_cnt = 0;
        bit stall_on = 1'b0;
        int tail_cnt = 0;
        g_data.delete(); g_sel.delete(); g_idx.delete(); g_last.delete();
        t_start = t_given; first_valid_edge = -1; last_acc_edge = -1; done_edge = -1;
        done_pulses = 0; stall_changes = 0; halt_gaps = 0; busy_at_done = -1; tail_busy = 0;
        halt_after_done = -1; dm_ren_count = 0; dm_ren_stall = 0; timed_out = 0;
        pd = '0; ps = 1'b0; pl = 1'b0; pi = '0;
        forever begin
            @(negedge clk);
            n = cyc;
            start = 1'b0;
            if (first_it && do_start) begin
                start = 1'b1;
                t_start = n + 1;
            end
            first_it = 1'b0;
            if (stop_rel >= 0 && n >= t_start + stop_rel) break;
            if (n > t_start + 20000) begin
                timed_out = 1;
                out_ready = 1'b0;
                break;
            end
            if (second_rel > 0 && n + 1 == t_start + second_rel) start = 1'b1;
            if (prev_stall && (out_valid !== 1'b1 || out_data !== pd || out_sel !== ps ||
                               out_index !== pi || out_last !== pl))
                stall_changes++;
            if (done === 1'b1) begin
                done_pulses++;
                if (done_edge < 0) begin
                    done_edge = n;
                    busy_at_done = int'(busy | halt_req);
                    if (start_on_done) start = 1'b1;
                end
            end else if (n >= t_start && done_edge < 0 && (busy !== 1'b1 || halt_req !== 1'b1)) begin
                halt_gaps++;
            end
            if (done_edge >= 0 && n > done_edge) begin
                tail_cnt++;
                if (busy === 1'b1) tail_busy++;
                if (tail_cnt == 1) halt_after_done = int'(halt_req);
            end
            if (out_valid === 1'b1 && first_valid_edge < 0) first_valid_edge = n;
            case (mode)
                0: r = 1'b1;
                1: r = ($urandom_range(0, 1) == 1);
                default: begin
                    if (!stall_on && out_valid === 1'b1 && out_sel === 1'b1 && out_index === 9'd100)
                        stall_on = 1'b1;
                    r = !(stall_on && stall_cnt < 20);
                    if (stall_on && stall_cnt < 20) begin
                        stall_cnt++;
                        if (dm_ren === 1'b1) dm_ren_stall++;
                    end
                end
            endcase
            if (dm_ren === 1'b1) dm_ren_count++;
            out_ready = r;
            if (out_valid === 1'b1 && r) begin
                g_data.push_back(out_data);
                g_sel.push_back(out_sel);
                g_idx.push_back(out_index);
                g_last.push_back(out_last);
                if (out_last === 1'b1) last_acc_edge = n + 1;
            end
            prev_stall = (out_valid === 1'b1) && !r;
            pd = out_data; ps = out_sel; pi = out_index; pl = out_last;
            if (done_edge >= 0 && tail_cnt >= tail) break;
        end
    endtask

    // Reference order: x0..x31 (sel 0), then dmem[0..511] (sel 1), last only on word 511.
    function automatic int seq_mismatch();
        if (g_data.size() != NWORDS) return -2;
        for (int p = 0; p < NWORDS; p++) begin
            logic [31:0] ed;
            logic es, el;
            int ei;
            if (p < RF_DEPTH) begin
                ed = rf_mem[p]; es = 1'b0; ei = p; el = 1'b0;
            end else begin
                ei = p - RF_DEPTH; ed = dm_mem[ei]; es = 1'b1; el = (ei == DMEM_WORDS - 1);
            end
            if (g_data[p] !== ed || g_sel[p] !== es || int'(g_idx[p]) != ei || g_last[p] !== el)
                return p;
        end
        return -1;
    endfunction

    function automatic int count_last();
        int c = 0;
        foreach (g_last[i]) if (g_last[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic randomize_mems();
        foreach (rf_mem[i]) rf_mem[i] = $urandom;
        foreach (dm_mem[i]) dm_mem[i] = $urandom;
    endtask

    task automatic test_reset();
        logic [61:0] outs;
        repeat (3) @(negedge clk);
        outs = {busy, done, halt_req, dm_ren, out_valid, out_sel, out_last,
                rf_raddr, dm_raddr, out_index, out_data};
        tests++;
        if (outs !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || halt_req !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b halt=%b valid=%b, expected 0 0 0", busy, halt_req, out_valid);
        end
    endtask

    task automatic test_nominal();
        int pos;
        collect(1'b1, 0, 0, 0, -1, 1'b0, 2);
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL nominal_seq: bad position %0d (words %0d), expected -1", pos, g_data.size()); end
        tests++;
        if (count_last() != 1) begin fails++; $display("FAIL nominal_last_count: got %0d, expected 1", count_last()); end
        tests++;
        if (first_valid_edge != t_start + 2) begin fails++; $display("FAIL nominal_first_valid: got edge %0d, expected %0d", first_valid_edge, t_start + 2); end
        tests++;
        if (last_acc_edge != t_start + 1570) begin fails++; $display("FAIL nominal_last_accept: got edge %0d, expected %0d", last_acc_edge, t_start + 1570); end
        tests++;
        if (done_edge != t_start + 1570) begin fails++; $display("FAIL nominal_done_time: got edge %0d, expected %0d", done_edge, t_start + 1570); end
        tests++;
        if (done_pulses != 1 || busy_at_done != 0) begin fails++; $display("FAIL nominal_done_pulse: pulses=%0d busy_at_done=%0d, expected 1 0", done_pulses, busy_at_done); end
        tests++;
        if (halt_gaps != 0) begin fails++; $display("FAIL nominal_halt_gaps: got %0d, expected 0", halt_gaps); end
        tests++;
        if (dm_ren_count != DMEM_WORDS) begin fails++; $display("FAIL nominal_dm_ren_count: got %0d, expected %0d", dm_ren_count, DMEM_WORDS); end
        tests++;
        if (timed_out != 0) begin fails++; $display("FAIL nominal_timeout: got %0d, expected 0", timed_out); end
    endtask

    task automatic test_random_ready();
        int pos;
        collect(1'b1, 0, 1, 0, -1, 1'b0, 1);
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL random_ready_seq: bad position %0d (words %0d), expected -1", pos, g_data.size()); end
        tests++;
        if (stall_changes != 0) begin fails++; $display("FAIL random_ready_stable: got %0d changes, expected 0", stall_changes); end
        tests++;
        if (done_pulses != 1 || halt_gaps != 0 || timed_out != 0) begin
            fails++;
            $display("FAIL random_ready_done: pulses=%0d gaps=%0d timeout=%0d, expected 1 0 0", done_pulses, halt_gaps, timed_out);
        end
    endtask

    task automatic test_stall_word100();
        int pos;
        randomize_mems();
        collect(1'b1, 0, 2, 0, -1, 1'b0, 1);
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL stall_seq: bad position %0d (words %0d), expected -1", pos, g_data.size()); end
        tests++;
        if (stall_changes != 0) begin fails++; $display("FAIL stall_stable: got %0d changes, expected 0", stall_changes); end
        tests++;
        if (dm_ren_stall != 1) begin fails++; $display("FAIL stall_dm_ren: got %0d reads during stall, expected 1", dm_ren_stall); end
        tests++;
        if (dm_ren_count != DMEM_WORDS) begin fails++; $display("FAIL stall_dm_ren_count: got %0d, expected %0d", dm_ren_count, DMEM_WORDS); end
    endtask

    task automatic test_second_start();
        int pos;
        randomize_mems();
        collect(1'b1, 0, 0, 50, -1, 1'b0, 6);
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL second_start_seq: bad position %0d (words %0d), expected -1", pos, g_data.size()); end
        tests++;
        if (done_pulses != 1 || tail_busy != 0) begin fails++; $display("FAIL second_start_done: pulses=%0d tail_busy=%0d, expected 1 0", done_pulses, tail_busy); end
        tests++;
        if (done_edge != t_start + 1570) begin fails++; $display("FAIL second_start_done_time: got %0d, expected %0d", done_edge, t_start + 1570); end
    endtask

    task automatic test_reset_mid();
        int pos;
        int late_done = 0;
        int late_busy = 0;
        logic [61:0] outs;
        randomize_mems();
        collect(1'b1, 0, 0, 0, 700, 1'b0, 1);
        tests++;
        if (busy !== 1'b1 || g_data.size() == 0) begin fails++; $display("FAIL mid_reset_precond: busy=%b words=%0d, expected 1 and >0", busy, g_data.size()); end
        rst = 1'b1;
        #1;
        outs = {busy, done, halt_req, dm_ren, out_valid, out_sel, out_last,
                rf_raddr, dm_raddr, out_index, out_data};
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL mid_reset_outputs: got %h, expected 0", outs); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) late_done++;
            if (busy === 1'b1) late_busy++;
        end
        tests++;
        if (late_done != 0 || late_busy != 0) begin fails++; $display("FAIL mid_reset_quiet: done=%0d busy=%0d, expected 0 0", late_done, late_busy); end
        collect(1'b1, 0, 1, 0, -1, 1'b0, 1);
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL restart_seq: bad position %0d (words %0d), expected -1", pos, g_data.size()); end
        tests++;
        if (first_valid_edge != t_start + 2) begin fails++; $display("FAIL restart_first_valid: got %0d, expected %0d", first_valid_edge, t_start + 2); end
    endtask

    task automatic test_start_in_done();
        int pos;
        int d;
        randomize_mems();
        collect(1'b1, 0, 0, 0, -1, 1'b1, 1);
        d = done_edge;
        tests++;
        if (halt_after_done != 1) begin fails++; $display("FAIL done_restart_halt: got %0d, expected 1", halt_after_done); end
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL done_restart_first_seq: bad position %0d, expected -1", pos); end
        collect(1'b0, d + 1, 0, 0, -1, 1'b0, 1);
        pos = seq_mismatch();
        tests++;
        if (pos != -1) begin fails++; $display("FAIL done_restart_second_seq: bad position %0d (words %0d), expected -1", pos, g_data.size()); end
        tests++;
        if (first_valid_edge != d + 3 || done_edge != d + 1571) begin
            fails++;
            $display("FAIL done_restart_timing: first=%0d done=%0d, expected %0d %0d", first_valid_edge, done_edge, d + 3, d + 1571);
        end
    endtask

    initial begin
        for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] = 32'(i) * 32'h1111_1111;
        for (int k = 0; k < DMEM_WORDS; k++) dm_mem[k] = 32'(k);
        test_reset();
        test_nominal();
        test_random_ready();
        test_stall_word100();
        test_second_start();
        test_reset_mid();
        test_start_in_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
